// File: rtl/instruction_decoder_pkg.sv
// Shared definitions for the instruction decoder slice.
// Purpose : data widths, opcode encodings, FSM state encoding and a small
//           opcode classification helper.
// Ports   : none (package).
package decoder_pkg;

  localparam int BYTE_W   = 8;
  localparam int WIDTH_IN = 2 * BYTE_W;
  localparam int CNT_W    = 3;   // shift amount is op[2:0]

  localparam logic [BYTE_W-1:0] OP_NOP  = 8'h00;
  localparam logic [BYTE_W-1:0] OP_LDI  = 8'h01;
  localparam logic [BYTE_W-1:0] OP_ADD  = 8'h02;
  localparam logic [BYTE_W-1:0] OP_SUB  = 8'h03;
  localparam logic [BYTE_W-1:0] OP_AND  = 8'h04;
  localparam logic [BYTE_W-1:0] OP_OR   = 8'h05;
  localparam logic [BYTE_W-1:0] OP_XOR  = 8'h06;
  localparam logic [BYTE_W-1:0] OP_SHL  = 8'h07;
  localparam logic [BYTE_W-1:0] OP_JMP  = 8'h08;
  localparam logic [BYTE_W-1:0] OP_JZ   = 8'h09;
  localparam logic [BYTE_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Opcodes whose result comes straight from the single-cycle ALU.
  function automatic logic is_alu_op(input logic [BYTE_W-1:0] opc);
    return (opc == OP_LDI) || (opc == OP_ADD) || (opc == OP_SUB) ||
           (opc == OP_AND) || (opc == OP_OR)  || (opc == OP_XOR);
  endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Fetch -> decoder link.
// Purpose : carries the instruction handshake and the jump report back to
//           the fetcher.
// Signals : start/data_in (fetcher -> decoder), ready (decoder -> fetcher),
//           jump_valid/jump_target (decoder -> fetcher).
// Handshake: a word transfers on every rising clk edge where start && ready.
//           start while ready is low is dropped, not queued; the fetcher
//           need not hold data_in stable once the transfer edge has passed.
interface instruction_decoder_if;
  import decoder_pkg::*;

  logic                start;
  logic [WIDTH_IN-1:0] data_in;
  logic                ready;
  logic                jump_valid;
  logic [BYTE_W-1:0]   jump_target;

  modport master (
    output start, data_in,
    input  ready, jump_valid, jump_target
  );

  modport slave (
    input  start, data_in,
    output ready, jump_valid, jump_target
  );
endinterface

// File: rtl/instruction_decoder_alu8.sv
// Combinational ALU for the accumulator datapath.
// Purpose : computes LDI/ADD/SUB/AND/OR/XOR results.
// Ports   : opc (opcode), a (accumulator), b (operand), cin (current carry)
//           -> y (result), cout (new carry), zero (y == 0).
// Logic ops and LDI pass cin through so the carry flag is preserved.
module alu8
  import decoder_pkg::*;
(
  input  logic [BYTE_W-1:0] opc,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] y,
  output logic              cout,
  output logic              zero
);

  always_comb begin
    y    = a;
    cout = cin;
    case (opc)
      OP_LDI: y = b;
      OP_ADD: {cout, y} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        y    = a - b;
        cout = (a < b);   // borrow
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: ;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder / executor.
// Purpose : accepts one 16-bit word (opcode:operand) per handshake on the
//           fetch link, executes it on an 8-bit accumulator and reports
//           jumps back to the fetcher.
// Ports   : clk, reset (sync, active-high)
//           fetch      - slave side of the fetch link
//           acc        - accumulator
//           zero_flag  - acc == 0 after last acc-writing op
//           carry_flag - carry/borrow/shift-out of last arithmetic/shift op
//           illegal_op - 1-cycle pulse, undefined opcode retired
//           exec_done  - 1-cycle pulse, instruction retired
//           halted     - sticky after HALT until reset
//           dbg_state  - current FSM state
module instruction_decoder
  import decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  instruction_decoder_if.slave fetch,
  output logic [BYTE_W-1:0]    acc,
  output logic                 zero_flag,
  output logic                 carry_flag,
  output logic                 illegal_op,
  output logic                 exec_done,
  output logic                 halted,
  output state_e               dbg_state
);

  state_e              state_q, state_d;
  logic [WIDTH_IN-1:0] ir_q, ir_d;
  logic [BYTE_W-1:0]   acc_q, acc_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                jump_valid_q, jump_valid_d;
  logic [BYTE_W-1:0]   jump_target_q, jump_target_d;
  logic                illegal_q, illegal_d;
  logic                done_q, done_d;
  logic                halted_q, halted_d;

  logic [BYTE_W-1:0]   opc;
  logic [BYTE_W-1:0]   opd;
  logic [BYTE_W-1:0]   alu_y;
  logic                alu_cout;
  logic                alu_zero;
  logic [BYTE_W-1:0]   shl_acc;

  assign opc     = ir_q[WIDTH_IN-1:BYTE_W];
  assign opd     = ir_q[BYTE_W-1:0];
  assign shl_acc = {acc_q[BYTE_W-2:0], 1'b0};

  alu8 u_alu (
    .opc  (opc),
    .a    (acc_q),
    .b    (opd),
    .cin  (carry_q),
    .y    (alu_y),
    .cout (alu_cout),
    .zero (alu_zero)
  );

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    acc_d         = acc_q;
    zero_d        = zero_q;
    carry_d       = carry_q;
    cnt_d         = cnt_q;
    jump_target_d = jump_target_q;
    halted_d      = halted_q;
    jump_valid_d  = 1'b0;
    illegal_d     = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch.start) begin
          ir_d    = fetch.data_in;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Most opcodes retire here; SHL n>0 and HALT override below.
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_alu_op(opc)) begin
          acc_d   = alu_y;
          carry_d = alu_cout;
          zero_d  = alu_zero;
        end else begin
          case (opc)
            OP_NOP: ;
            OP_SHL: begin
              if (opd[CNT_W-1:0] != '0) begin
                cnt_d   = opd[CNT_W-1:0];
                state_d = ST_SHIFT;
                done_d  = 1'b0;
              end
            end
            OP_JMP: begin
              jump_valid_d  = 1'b1;
              jump_target_d = opd;
            end
            OP_JZ: begin
              if (zero_q) begin
                jump_valid_d  = 1'b1;
                jump_target_d = opd;
              end
            end
            OP_HALT: begin
              state_d  = ST_HALTED;
              halted_d = 1'b1;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end

      ST_SHIFT: begin
        // One bit per cycle; the last bit shifted out is the final carry.
        carry_d = acc_q[BYTE_W-1];
        acc_d   = shl_acc;
        zero_d  = (shl_acc == '0);
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_HALTED: ;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      acc_q         <= '0;
      zero_q        <= 1'b1;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      jump_valid_q  <= 1'b0;
      jump_target_q <= '0;
      illegal_q     <= 1'b0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      acc_q         <= acc_d;
      zero_q        <= zero_d;
      carry_q       <= carry_d;
      cnt_q         <= cnt_d;
      jump_valid_q  <= jump_valid_d;
      jump_target_q <= jump_target_d;
      illegal_q     <= illegal_d;
      done_q        <= done_d;
      halted_q      <= halted_d;
    end
  end

  assign fetch.ready       = (state_q == ST_IDLE);
  assign fetch.jump_valid  = jump_valid_q;
  assign fetch.jump_target = jump_target_q;
  assign acc               = acc_q;
  assign zero_flag         = zero_q;
  assign carry_flag        = carry_q;
  assign illegal_op        = illegal_q;
  assign exec_done         = done_q;
  assign halted            = halted_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_instruction_decoder.sv
module tb_instruction_decoder;
  import decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_decoder_if dif();

  logic [7:0] acc;
  logic       zero_flag, carry_flag, illegal_op, exec_done, halted;
  state_e     dbg_state;

  instruction_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .fetch      (dif),
    .acc        (acc),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .illegal_op (illegal_op),
    .exec_done  (exec_done),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int m_acc, m_zero, m_carry;
  int e_lat, e_jump, e_target, e_ill, e_halt;
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    m_acc = 0; m_zero = 1; m_carry = 0;
  endfunction

  function automatic void model_step(input int opc, input int opd);
    int s, n;
    e_lat = 1; e_jump = 0; e_target = 0; e_ill = 0; e_halt = 0;
    case (opc)
      0: ;
      1: begin m_acc = opd; m_zero = (m_acc == 0); end
      2: begin s = m_acc + opd; m_carry = (s > 255); m_acc = s % 256; m_zero = (m_acc == 0); end
      3: begin m_carry = (m_acc < opd); m_acc = (m_acc - opd + 256) % 256; m_zero = (m_acc == 0); end
      4: begin m_acc = m_acc & opd; m_zero = (m_acc == 0); end
      5: begin m_acc = m_acc | opd; m_zero = (m_acc == 0); end
      6: begin m_acc = m_acc ^ opd; m_zero = (m_acc == 0); end
      7: begin
        n = opd % 8;
        for (int i = 0; i < n; i++) begin
          m_carry = (m_acc / 128) % 2;
          m_acc   = (m_acc * 2) % 256;
          m_zero  = (m_acc == 0);
        end
        e_lat = 1 + n;
      end
      8: begin e_jump = 1; e_target = opd; end
      9: if (m_zero != 0) begin e_jump = 1; e_target = opd; end
      255: e_halt = 1;
      default: e_ill = 1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    dif.start = 1'b0;
    dif.data_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // Called just after a negedge; leaves at a negedge.
  task automatic issue(input logic [7:0] opc, input logic [7:0] opd);
    int waited, lat, early;
    logic [7:0] exp_acc;
    waited = 0;
    while (dif.ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (dif.ready !== 1'b1) begin
      $display("FAIL ready_wait op=%02h: ready=%b required 1", opc, dif.ready);
      return;
    end
    n_pass++;
    model_step(int'(opc), int'(opd));
    exp_q.push_back(8'(m_acc));
    dif.start = 1'b1;
    dif.data_in = {opc, opd};
    @(negedge clk);
    dif.start = 1'b0;
    dif.data_in = 16'($urandom);

    if (e_halt != 0) begin
      n_checks++;
      if (dif.ready !== 1'b0 || exec_done !== 1'b0)
        $display("FAIL halt_exec: ready=%b exec_done=%b required 0/0", dif.ready, exec_done);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (exec_done !== 1'b1 || halted !== 1'b1 || dif.ready !== 1'b0)
        $display("FAIL halt_retire: exec_done=%b halted=%b ready=%b required 1/1/0", exec_done, halted, dif.ready);
      else n_pass++;
      exp_acc = exp_q.pop_front();
      n_checks++;
      if (acc !== exp_acc) $display("FAIL halt_acc: acc=%02h required %02h", acc, exp_acc);
      else n_pass++;
      return;
    end

    lat = 0;
    early = 0;
    while (dif.ready !== 1'b1 && lat < 40) begin
      if (exec_done !== 1'b0) early = 1;
      lat++;
      @(negedge clk);
    end
    n_checks++;
    if (lat != e_lat) $display("FAIL latency op=%02h %02h: ready low %0d cycles required %0d", opc, opd, lat, e_lat);
    else n_pass++;
    n_checks++;
    if (early != 0) $display("FAIL early_done op=%02h: exec_done seen while ready=0, required none", opc);
    else n_pass++;
    n_checks++;
    if (exec_done !== 1'b1) $display("FAIL exec_done op=%02h: exec_done=%b required 1", opc, exec_done);
    else n_pass++;
    n_checks++;
    if (dif.jump_valid !== 1'(e_jump)) $display("FAIL jump_valid op=%02h: jump_valid=%b required %0d", opc, dif.jump_valid, e_jump);
    else n_pass++;
    if (e_jump != 0) begin
      n_checks++;
      if (dif.jump_target !== 8'(e_target)) $display("FAIL jump_target: jump_target=%02h required %02h", dif.jump_target, e_target);
      else n_pass++;
    end
    n_checks++;
    if (illegal_op !== 1'(e_ill)) $display("FAIL illegal_op op=%02h: illegal_op=%b required %0d", opc, illegal_op, e_ill);
    else n_pass++;
    exp_acc = exp_q.pop_front();
    n_checks++;
    if (acc !== exp_acc) $display("FAIL acc op=%02h %02h: acc=%02h required %02h", opc, opd, acc, exp_acc);
    else n_pass++;
    n_checks++;
    if (zero_flag !== 1'(m_zero) || carry_flag !== 1'(m_carry))
      $display("FAIL flags op=%02h %02h: zero=%b carry=%b required %0d/%0d", opc, opd, zero_flag, carry_flag, m_zero, m_carry);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dif.ready !== 1'b1 || acc !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0)
      $display("FAIL reset_core: ready=%b acc=%02h zero=%b carry=%b required 1/00/1/0", dif.ready, acc, zero_flag, carry_flag);
    else n_pass++;
    n_checks++;
    if (exec_done !== 1'b0 || illegal_op !== 1'b0 || dif.jump_valid !== 1'b0 || halted !== 1'b0 || dif.jump_target !== 8'h00)
      $display("FAIL reset_pulses: done=%b ill=%b jv=%b halted=%b jt=%02h required all 0", exec_done, illegal_op, dif.jump_valid, halted, dif.jump_target);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_arith();
    issue(8'h01, 8'h05);
    issue(8'h02, 8'hFF);
    issue(8'h01, 8'h03);
    issue(8'h03, 8'h03);
    issue(8'h03, 8'h01);
    issue(8'h04, 8'h0F);
    issue(8'h05, 8'h30);
    issue(8'h06, 8'hFF);
  endtask

  task automatic test_shift();
    issue(8'h01, 8'h81);
    issue(8'h07, 8'h03);
    issue(8'h07, 8'h00);
    issue(8'h07, 8'hF8);   // op[2:0]=0 with upper operand bits set
    issue(8'h07, 8'h07);
  endtask

  task automatic test_jump();
    issue(8'h01, 8'h00);
    issue(8'h09, 8'h40);
    issue(8'h01, 8'h01);
    issue(8'h09, 8'h40);
    issue(8'h08, 8'h22);
  endtask

  task automatic test_illegal();
    issue(8'h01, 8'h5A);
    issue(8'h55, 8'h12);
    issue(8'h0A, 8'h00);
    issue(8'hFE, 8'h77);
  endtask

  task automatic test_random();
    logic [7:0] opc;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) opc = 8'($urandom_range(10, 254));
      else opc = 8'($urandom_range(0, 9));
      issue(opc, 8'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Each issue starts in the cycle its predecessor's exec_done is high.
    issue(8'h01, 8'h10);
    cyc = 0;
    issue(8'h02, 8'h01);
    issue(8'h02, 8'h01);
    // A start held while ready=0 must be dropped.
    dif.start = 1'b1;
    dif.data_in = {8'h01, 8'h77};
    @(negedge clk);
    dif.data_in = {8'h02, 8'h01};
    @(negedge clk);
    dif.start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++;
    if (acc !== 8'h77 || dif.ready !== 1'b1 || exec_done !== 1'b0)
      $display("FAIL dropped_start: acc=%02h ready=%b done=%b required 77/1/0", acc, dif.ready, exec_done);
    else n_pass++;
    m_acc = 'h77; m_zero = 0;
  endtask

  task automatic test_reset_mid_shift();
    issue(8'h01, 8'h81);
    dif.start = 1'b1;
    dif.data_in = {8'h07, 8'h05};
    @(negedge clk);            // EXEC
    dif.start = 1'b0;
    @(negedge clk);            // SHIFT cycle 1
    @(negedge clk);            // SHIFT cycle 2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (acc !== 8'h00 || dif.ready !== 1'b1 || exec_done !== 1'b0 || zero_flag !== 1'b1 || carry_flag !== 1'b0)
      $display("FAIL reset_mid_shift: acc=%02h ready=%b done=%b zero=%b carry=%b required 00/1/0/1/0", acc, dif.ready, exec_done, zero_flag, carry_flag);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (exec_done !== 1'b0 || acc !== 8'h00)
      $display("FAIL reset_mid_shift_after: done=%b acc=%02h required 0/00", exec_done, acc);
    else n_pass++;
    issue(8'h02, 8'h09);
  endtask

  task automatic test_halt();
    int bad;
    issue(8'h01, 8'h3C);
    issue(8'hFF, 8'h00);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      dif.start = 1'b1;
      dif.data_in = {8'h01, 8'($urandom)};
      @(negedge clk);
      if (dif.ready !== 1'b0 || exec_done !== 1'b0 || halted !== 1'b1 || acc !== 8'h3C) bad = 1;
    end
    dif.start = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL halted_sticky: ready=%b done=%b halted=%b acc=%02h required 0/0/1/3c", dif.ready, exec_done, halted, acc);
    else n_pass++;
    do_reset();
    n_checks++;
    if (halted !== 1'b0 || dif.ready !== 1'b1) $display("FAIL halt_reset: halted=%b ready=%b required 0/1", halted, dif.ready);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    dif.start = 1'b0;
    dif.data_in = '0;
    model_reset();
    test_reset();
    test_arith();
    test_shift();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
